// File: rtl/register_nbit_pkg.sv
// ============================================================================
// Module   : register_nbit_pkg
// Summary  : Shared types, default decode window and size-to-byte-enable
//            helper for the memory-mapped N-bit register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_nbit_pkg;

  typedef enum logic [1:0] {
    SIZE_8  = 2'b00,
    SIZE_16 = 2'b01,
    SIZE_32 = 2'b10,
    SIZE_64 = 2'b11
  } size_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_ADDR_MASK = 32'hFFFF_FF00;

  // Byte lanes 0..(2^size)-1 are enabled; bit k enables byte k.
  function automatic logic [7:0] size_to_byte_en(input logic [1:0] size);
    case (size_e'(size))
      SIZE_8:  return 8'h01;
      SIZE_16: return 8'h03;
      SIZE_32: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_nbit_if.sv
// ============================================================================
// Module   : register_nbit_if
// Summary  : Bus bundle between a master and the N-bit register slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_nbit_if #(
  parameter int N = 32
) ();

  logic [31:0]  address;
  logic [N-1:0] wdata;
  logic         mem_write;
  logic         mem_read;
  logic [1:0]   size;
  logic         chip_select;
  logic [N-1:0] q;
  logic [N-1:0] rdata;
  logic         rdata_valid;

  modport master (
    output address, wdata, mem_write, mem_read, size,
    input  chip_select, q, rdata, rdata_valid
  );

  modport slave (
    input  address, wdata, mem_write, mem_read, size,
    output chip_select, q, rdata, rdata_valid
  );

endinterface

`default_nettype wire

// File: rtl/register_nbit_address_detect.sv
// ============================================================================
// Module   : address_detect
// Summary  : Combinational address-window decoder, shared by peripherals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module address_detect #(
  parameter logic [31:0] base_address = 32'h8000_0000,
  parameter logic [31:0] address_mask = 32'hFFFF_FF00
) (
  input  wire logic [31:0] address,
  output logic             chip_select
);

  assign chip_select = ((address & address_mask) == (base_address & address_mask));

endmodule

`default_nettype wire

// File: rtl/register_nbit.sv
// ============================================================================
// Module   : register_nbit
// Summary  : Memory-mapped N-bit storage register with window decode.
//            REGISTER_NBIT_PARTIAL_WRITE_EN enables size-based byte-lane
//            writes; otherwise every write loads all N bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_nbit
  import register_nbit_pkg::*;
#(
  parameter int          N           = 32,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK   = DEFAULT_ADDR_MASK,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  register_nbit_if.slave  bus
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic [N-1:0] bit_en;
  logic [7:0]   byte_en;
  logic         chip_select;
  logic         write_en;
  logic         read_en;

  address_detect #(
    .base_address (BASE_ADDR),
    .address_mask (ADDR_MASK)
  ) u_address_detect (
    .address     (bus.address),
    .chip_select (chip_select)
  );

  // Simultaneous strobes are illegal and suppress both operations.
  assign write_en = chip_select & bus.mem_write & ~bus.mem_read;
  assign read_en  = chip_select & bus.mem_read  & ~bus.mem_write;

`ifdef REGISTER_NBIT_PARTIAL_WRITE_EN
  assign byte_en = size_to_byte_en(bus.size);
`else
  logic unused_size;
  assign unused_size = ^bus.size;
  assign byte_en     = 8'hFF;
`endif

  // A partial top byte simply maps its bits onto that lane's enable.
  for (genvar i = 0; i < N; i++) begin : g_bit_en
    assign bit_en[i] = byte_en[i / 8];
  end

  always_comb begin
    q_d = q_q;
    if (write_en) begin
      q_d = (q_q & ~bit_en) | (bus.wdata & bit_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.chip_select = chip_select;
  assign bus.q           = q_q;
  assign bus.rdata       = read_en ? q_q : '0;
  assign bus.rdata_valid = read_en;

endmodule

`default_nettype wire

// File: tb/tb_register_nbit.sv
// ============================================================================
// Module   : tb_register_nbit
// Summary  : Self-checking bench for register_nbit: directed scenarios plus
//            randomized traffic against a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_nbit;

  localparam logic [31:0] RST_VAL = 32'hA5A5_0000;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam logic [31:0] MASK    = 32'hFFFF_FF00;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model_q;

  register_nbit_if #(.N(32)) bus ();

  register_nbit #(
    .N           (32),
    .BASE_ADDR   (BASE),
    .ADDR_MASK   (MASK),
    .RESET_VALUE (RST_VAL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hit(input logic [31:0] a);
    return (a & MASK) == (BASE & MASK);
  endfunction

  // Writes replace the low 2^size bytes (or the whole word without lane support).
  function automatic logic [31:0] model_write(input logic [31:0] cur, input logic [31:0] wd,
                                              input logic [1:0] sz);
    logic [31:0] res;
    int nbytes;
    res = cur;
`ifdef REGISTER_NBIT_PARTIAL_WRITE_EN
    nbytes = 1 << sz;
`else
    nbytes = 4 + 0 * int'(sz);
`endif
    for (int b = 0; b < 4; b++)
      if (b < nbytes) res[b*8 +: 8] = wd[b*8 +: 8];
    return res;
  endfunction

  // Called just after a rising edge: drive, check combinational outputs,
  // cross the next edge, then check the stored value.
  task automatic step(input logic [31:0] a, input logic [31:0] wd,
                      input logic wr, input logic rd, input logic [1:0] sz);
    logic hit, rd_ok;
    bus.address   = a;
    bus.wdata     = wd;
    bus.mem_write = wr;
    bus.mem_read  = rd;
    bus.size      = sz;
    #2;
    hit   = model_hit(a);
    rd_ok = hit && rd && !wr;
    check_eq("chip_select", {63'd0, bus.chip_select}, {63'd0, hit});
    check_eq("rdata_valid", {63'd0, bus.rdata_valid}, {63'd0, rd_ok});
    check_eq("rdata", {32'd0, bus.rdata}, {32'd0, rd_ok ? model_q : 32'd0});
    @(posedge clk);
    #1;
    if (hit && wr && !rd && !rst) model_q = model_write(model_q, wd, sz);
    check_eq("q", {32'd0, bus.q}, {32'd0, model_q});
  endtask

  initial begin
    bus.address   = '0;
    bus.wdata     = '0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.size      = 2'b00;
    model_q       = 32'h0;

    // Asynchronous reset asserted mid-cycle
    @(posedge clk); #3;
    rst = 1'b1;
    model_q = RST_VAL;
    #1;
    check_eq("reset_async_q", {32'd0, bus.q}, {32'd0, RST_VAL});
    @(posedge clk); #1;
    step(32'h8000_0004, 32'h0, 1'b0, 1'b1, 2'b10);
    step(32'h8000_0004, 32'h1111_2222, 1'b1, 1'b0, 2'b10);
    rst = 1'b0;

    // Full write then read
    step(32'h8000_0010, 32'h1234_5678, 1'b1, 1'b0, 2'b10);
    check_eq("full_write", {32'd0, bus.q}, {32'd0, 32'h1234_5678});
    step(32'h8000_0010, 32'h0, 1'b0, 1'b1, 2'b10);

    // Partial (byte / halfword) writes
    step(32'h8000_0010, 32'hFFFF_FFAB, 1'b1, 1'b0, 2'b00);
`ifdef REGISTER_NBIT_PARTIAL_WRITE_EN
    check_eq("byte_write", {32'd0, bus.q}, {32'd0, 32'h1234_56AB});
    step(32'h8000_0010, 32'h0000_CDEF, 1'b1, 1'b0, 2'b01);
    check_eq("half_write", {32'd0, bus.q}, {32'd0, 32'h1234_CDEF});
`else
    check_eq("byte_write_full", {32'd0, bus.q}, {32'd0, 32'hFFFF_FFAB});
`endif

    // Miss and illegal access
    step(32'h8000_0100, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b10);
    step(32'h8000_0100, 32'h0, 1'b0, 1'b1, 2'b10);
    step(32'h8000_0020, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b10);

    // Read issued the cycle after a write sees the new value
    step(32'h8000_00FC, 32'h0BAD_F00D, 1'b1, 1'b0, 2'b11);
    step(32'h8000_00FC, 32'h0, 1'b0, 1'b1, 2'b00);

    // Randomized traffic with occasional asynchronous reset pulses
    for (int it = 0; it < 400; it++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) != 0) a = BASE | {24'd0, 8'($urandom)};
      else                           a = $urandom;
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst = 1'b1;
        model_q = RST_VAL;
        #1;
        check_eq("rand_reset_q", {32'd0, bus.q}, {32'd0, RST_VAL});
        @(posedge clk); #1;
        rst = 1'b0;
      end
      step(a, $urandom, 1'($urandom), 1'($urandom), 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
